// File: rtl/vslc_scan_scheduler.sv
// vslc_scan_scheduler: PLC-style scan-cycle sequencer for the vslc core.
//
// Each scan freezes the raw input pins into an input image, resets the core PC,
// strobes the core one instruction at a time until it reports end-of-program,
// then commits the core output image to the pins and waits out the rest of the
// programmed scan period. A per-scan step watchdog forces a sticky fault state
// with safe (all-zero) outputs if the program never finishes.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   en             run enable, looked at only when idle or between scans
//   period         scan period (start-to-start) in clk cycles, 0 = free-run
//   in_pins        raw input pins
//   in_image       input image frozen at scan start, fed to the core
//   core_pc_rst    one-cycle pulse at scan start, core PC to 0
//   core_step      step strobe, one instruction per high cycle
//   core_done      core end-of-program flag, valid the cycle after a step
//   core_out       core output image
//   out_pins       committed output image
//   scan_tick      one-cycle pulse in the commit cycle
//   busy           high while sampling, executing or committing
//   fault          watchdog fault, held until fault_clr
//   fault_clr      leaves the fault state
//   scan_count     completed scans, wrapping 16-bit counter
module vslc_scan_scheduler #(
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned STEP_W    = 10,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          in_pins,
  output logic [7:0]          in_image,
  output logic                core_pc_rst,
  output logic                core_step,
  input  logic                core_done,
  input  logic [7:0]          core_out,
  output logic [7:0]          out_pins,
  output logic                scan_tick,
  output logic                busy,
  output logic                fault,
  input  logic                fault_clr,
  output logic [15:0]         scan_count
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSample = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StUpdate = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;
  localparam logic [2:0] StFault  = 3'd5;

  localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);

  logic [2:0]          state_q, state_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [PERIOD_W-1:0] period_dec;
  logic                period_done;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                check_q, check_d;  // EXEC phase: 0 = step cycle, 1 = check cycle
  logic [7:0]          in_image_q, in_image_d;
  logic [7:0]          out_pins_q, out_pins_d;
  logic [15:0]         scan_count_q, scan_count_d;

  // Saturating down-count; the scan is over once the count for the next cycle
  // reaches zero, so start-to-start spacing equals the loaded period.
  assign period_dec  = (period_cnt_q == '0) ? '0 : period_cnt_q - PERIOD_W'(1);
  assign period_done = (period_dec == '0);

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    step_cnt_d   = step_cnt_q;
    check_d      = check_q;
    in_image_d   = in_image_q;
    out_pins_d   = out_pins_q;
    scan_count_d = scan_count_q;

    if (state_q != StIdle) begin
      period_cnt_d = period_dec;
    end

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d      = StSample;
          period_cnt_d = period;
        end
      end

      StSample: begin
        in_image_d = in_pins;
        step_cnt_d = '0;
        check_d    = 1'b0;
        state_d    = StExec;
      end

      StExec: begin
        if (!check_q) begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
          check_d    = 1'b1;
        end else begin
          check_d = 1'b0;
          if (core_done) begin
            state_d = StUpdate;
          end else if (step_cnt_q == MaxSteps) begin
            state_d    = StFault;
            out_pins_d = '0;
          end
        end
      end

      StUpdate: begin
        out_pins_d   = core_out;
        scan_count_d = scan_count_q + 16'd1;
        // An overrun scan skips WAIT entirely.
        if (!period_done) begin
          state_d = StWait;
        end else if (en) begin
          state_d      = StSample;
          period_cnt_d = period;
        end else begin
          state_d = StIdle;
        end
      end

      StWait: begin
        if (period_done) begin
          if (en) begin
            state_d      = StSample;
            period_cnt_d = period;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StFault: begin
        if (fault_clr) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      step_cnt_q   <= '0;
      check_q      <= 1'b0;
      in_image_q   <= '0;
      out_pins_q   <= '0;
      scan_count_q <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      step_cnt_q   <= step_cnt_d;
      check_q      <= check_d;
      in_image_q   <= in_image_d;
      out_pins_q   <= out_pins_d;
      scan_count_q <= scan_count_d;
    end
  end

  assign in_image    = in_image_q;
  assign out_pins    = out_pins_q;
  assign scan_count  = scan_count_q;
  assign core_pc_rst = (state_q == StSample);
  assign core_step   = (state_q == StExec) && !check_q;
  assign scan_tick   = (state_q == StUpdate);
  assign busy        = (state_q == StSample) || (state_q == StExec) || (state_q == StUpdate);
  assign fault       = (state_q == StFault);

endmodule
